dm_bytelane: RTL
================

Name: dm_bytelane

Overview:
- Parametrised successor to the 4 KB data memory in the single-cycle and pipelined CPUs.
- Stores place bytes and halfwords into the addressed byte lane with true byte-enable merge; the other bytes of the word are kept.
- Loads select, sign-extend or zero-extend by address offset, with registered read data and a req/ready/rvalid handshake.
- Adds misalignment detection, a configurable endianness, and a sequential memory clear after reset (replaces the single-cycle clear loop).

Parameters:
- ADDR_W, 10, word-address bits; DEPTH = 2**ADDR_W words of 32 bits.
- BIG_ENDIAN, 1, 1 = byte offset 0 maps to bits [31:24]; 0 = byte offset 0 maps to bits [7:0].

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- req  in  1  access request; qualifies DataAddr/WriteData/MemWrite/MemRead.
- DataAddr  in  32  byte address; bits [ADDR_W+1:2] select the word, [1:0] the byte offset, higher bits ignored.
- WriteData  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- MemWrite  in  2  00 none, 01 sh, 10 sb, 11 sw.
- MemRead  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101..111 none.
- ready  out  1  1 = request is accepted this cycle.
- rvalid  out  1  one-cycle pulse; ReadData/misalign are valid.
- ReadData  out  32  load result.
- misalign  out  1  accepted access was misaligned; qualified by rvalid.
- busy  out  1  memory clear in progress.

Behaviour:
- Reset (rst==0 at posedge):
  - State goes to CLEAR, clear_idx=0.
  - rvalid=0, misalign=0, ReadData=0, busy=1, ready=0.
  - Any in-flight read is dropped.
- CLEAR state:
  - Writes 0 to dm[clear_idx] each cycle, then increments clear_idx.
  - While rst is held low, clear_idx stays at 0.
  - After the write of index DEPTH-1, the next state is RUN. busy=0 and ready=1 from that cycle onward.
  - Clear takes DEPTH cycles after rst deasserts.
- RUN state:
  - ready=1 combinationally.
  - Accept = req && ready. req is ignored while busy; the requester holds its request.
- Alignment:
  - sh/lh/lhu require DataAddr[0]==0.
  - sw/lw require DataAddr[1:0]==0.
  - sb/lb/lbu are always aligned.
- Store on an accepted aligned access (committed at that posedge):
  - Only the addressed lanes change; the other bytes of the word are unchanged.
  - sb writes WriteData[7:0] to lane off.
  - sh writes WriteData[15:8] to lane off and WriteData[7:0] to lane off+1 (big-endian). Little-endian swaps the lane order.
  - sw writes the whole word.
- Load on an accepted access with a valid MemRead code:
  - rvalid=1 on the next cycle only.
  - lb/lbu extract the byte at lane off; lh/lhu extract the halfword at off; then sign- or zero-extend to 32 bits.
- Read and write in the same accepted request: the read returns the pre-write contents (read-before-write); the write still commits.
- Misaligned accepted access (load or store):
  - No memory write.
  - Next cycle: rvalid=1, misalign=1, ReadData=0. A misaligned store alone also produces this pulse.
- Accepted request with MemWrite=00 and MemRead none: no effect, no rvalid.
- Back-to-back accepts are allowed, one per cycle; rvalid pulses per load in order.
- Read-after-write to the same word in consecutive cycles returns the new data.
- ReadData holds its last value while rvalid=0; misalign=0 when rvalid=0.

Test Plan:
- Clear: ADDR_W=4, pre-load garbage, pulse rst low 3 cycles.
  - busy stays high exactly 16 cycles after rst rises; ready=0 throughout.
  - lw of every word then returns 0x00000000.
- Byte merge, big-endian: sw 0x11223344 @0x10; sb 0xAA @0x12; lw @0x10.
  - rvalid 1 cycle after the lw accept, ReadData=0x1122AA44.
  - Repeat with BIG_ENDIAN=0 and sb @0x11: ReadData=0x1122AA44.
- Extension: word 0x80FF7F01 @0x20 (BE).
  - lb @0x20 → 0xFFFFFF80; lbu @0x20 → 0x00000080.
  - lh @0x22 → 0x00007F01; lhu @0x20 → 0x000080FF; lh @0x20 → 0xFFFF80FF.
- Misalign: sw 0xDEADBEEF @0x31 → rvalid=1, misalign=1, memory unchanged (lw @0x30 returns the prior value). lh @0x33 → misalign=1, ReadData=0.
- Simultaneous read and write: word = 0x01020304; accepted request with sw 0x55667788 and lw @ same address → ReadData=0x01020304. The next lw returns 0x55667788.
- Reset mid-stream: issue lw, then drop rst the same cycle → no rvalid pulse; busy=1 and the clear restarts from index 0.

Source files
------------

// File: rtl/dm_bytelane.sv
// Byte-lane data memory: merged sb/sh/sw stores, extended loads with registered
// read data, misalignment reporting and a sequential clear after reset.
module dm_bytelane #(
  parameter int unsigned ADDR_W     = 10,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteData,
  input  logic [1:0]  MemWrite,
  input  logic [2:0]  MemRead,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] ReadData,
  output logic        misalign,
  output logic        busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [1:0] MW_SH  = 2'b01;
  localparam logic [1:0] MW_SB  = 2'b10;
  localparam logic [1:0] MW_SW  = 2'b11;
  localparam logic [2:0] MR_LW  = 3'd0;
  localparam logic [2:0] MR_LH  = 3'd1;
  localparam logic [2:0] MR_LHU = 3'd2;
  localparam logic [2:0] MR_LB  = 3'd3;
  localparam logic [2:0] MR_LBU = 3'd4;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clear_idx;
  logic [31:0]         dm [DEPTH];

  logic [ADDR_W-1:0]   word;
  logic [1:0]          off;
  logic [1:0]          bpos;
  logic [1:0]          hpos;
  logic                accept;
  logic                rd_en;
  logic                wr_en;
  logic                mis;
  logic [31:0]         rword;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [31:0]         load_val;
  logic [3:0]          we;
  logic [ADDR_W-1:0]   waddr;
  logic [31:0]         wdata;
  logic                unused_addr;

  assign word        = DataAddr[ADDR_W+1:2];
  assign off         = DataAddr[1:0];
  assign unused_addr = ^DataAddr[31:ADDR_W+2];

  assign ready  = (state == RUN);
  assign busy   = (state == CLEAR);
  assign accept = req && ready && rst;

  assign rd_en = (MemRead <= MR_LBU);
  assign wr_en = (MemWrite != 2'b00);
  assign mis   = ((MemWrite == MW_SH) && off[0]) ||
                 ((MemWrite == MW_SW) && (off != 2'b00)) ||
                 ((MemRead == MR_LW) && (off != 2'b00)) ||
                 (((MemRead == MR_LH) || (MemRead == MR_LHU)) && off[0]);

  // Physical byte position of the addressed lane and of the low byte of a halfword
  assign bpos = BIG_ENDIAN ? ~off : off;
  assign hpos = BIG_ENDIAN ? {~off[1], 1'b0} : {off[1], 1'b0};

  assign rword    = dm[word];
  assign byte_sel = 8'(rword >> {bpos, 3'b000});
  assign half_sel = 16'(rword >> {hpos, 3'b000});

  always_comb begin
    load_val = '0;
    case (MemRead)
      MR_LW:   load_val = rword;
      MR_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      MR_LHU:  load_val = {16'h0000, half_sel};
      MR_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      MR_LBU:  load_val = {24'h000000, byte_sel};
      default: load_val = '0;
    endcase
  end

  // Write port shared by the clear sequencer and aligned stores
  always_comb begin
    we    = 4'b0000;
    waddr = word;
    wdata = WriteData;
    if ((state == CLEAR) && rst) begin
      we    = 4'b1111;
      waddr = clear_idx;
      wdata = '0;
    end else if (accept && !mis && wr_en) begin
      case (MemWrite)
        MW_SB: begin
          we    = 4'b0001 << bpos;
          wdata = {4{WriteData[7:0]}};
        end
        MW_SH: begin
          we    = 4'b0011 << hpos;
          wdata = {2{WriteData[15:0]}};
        end
        MW_SW: begin
          we    = 4'b1111;
          wdata = WriteData;
        end
        default: we = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) dm[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= CLEAR;
      clear_idx <= '0;
      rvalid    <= 1'b0;
      misalign  <= 1'b0;
      ReadData  <= '0;
    end else begin
      rvalid   <= 1'b0;
      misalign <= 1'b0;
      case (state)
        CLEAR: begin
          clear_idx <= clear_idx + ADDR_W'(1);
          if (clear_idx == ADDR_W'(DEPTH - 1)) state <= RUN;
        end
        RUN: begin
          if (accept && (mis || rd_en)) begin
            rvalid   <= 1'b1;
            misalign <= mis;
            ReadData <= mis ? 32'h0 : load_val;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
